// File: rtl/ssc_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : ssc_result_checker
// Description : BIST response checker for the sort selection circuit. After
//               the sorter's done pulse it reads N_WORDS words from address
//               0, flags every word smaller than its predecessor (unsigned),
//               records the first offending address and folds every word
//               into a 16-bit MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module ssc_result_checker #(
    parameter int          N_WORDS   = 256,
    parameter logic [15:0] MISR_POLY = 16'h002D,
    parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Read_data,
    output logic [7:0]  address,
    output logic        read,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_addr,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_last_addr = 8'(N_WORDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_idx;
    logic        r_cap_valid;   // a read was issued last cycle
    logic [7:0]  r_cap_addr;    // address of that read
    logic [15:0] r_prev;
    logic        r_pass;
    logic [7:0]  r_err_count;
    logic [7:0]  r_first_err_addr;
    logic [15:0] r_signature;

    logic        w_viol;
    logic [7:0]  w_err_next;
    logic [15:0] w_sig_next;

    // The word at address 0 has no predecessor, so it can never violate.
    assign w_viol     = r_cap_valid && (r_cap_addr != 8'd0) && (Read_data < r_prev);
    assign w_err_next = r_err_count + {7'd0, w_viol};
    assign w_sig_next = {r_signature[14:0], 1'b0}
                      ^ (r_signature[15] ? MISR_POLY : 16'h0000)
                      ^ Read_data;

    assign read           = (r_state == S_SCAN);
    assign address        = r_idx;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign signature      = r_signature;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so it is ignored while busy
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SCAN;
            S_SCAN:  if (r_idx == c_last_addr) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address sequencing, word capture, MISR and violation bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx            <= 8'd0;
            r_cap_valid      <= 1'b0;
            r_cap_addr       <= 8'd0;
            r_prev           <= 16'd0;
            r_pass           <= 1'b0;
            r_err_count      <= 8'd0;
            r_first_err_addr <= 8'd0;
            r_signature      <= 16'd0;
        end else begin
            r_cap_valid <= (r_state == S_SCAN);
            r_cap_addr  <= r_idx;

            if (r_state == S_IDLE && start) begin
                r_idx            <= 8'd0;
                r_signature      <= MISR_SEED;
                r_err_count      <= 8'd0;
                r_first_err_addr <= 8'd0;
                r_pass           <= 1'b0;
            end

            // Index saturates at the last address so it never runs past it
            if (r_state == S_SCAN && r_idx != c_last_addr) begin
                r_idx <= r_idx + 8'd1;
            end

            // Captures only happen in SCAN/DRAIN, never alongside a start
            if (r_cap_valid) begin
                r_signature <= w_sig_next;
                r_prev      <= Read_data;
                r_err_count <= w_err_next;
                if (w_viol && r_err_count == 8'd0) begin
                    r_first_err_addr <= r_cap_addr;
                end
            end

            // DRAIN holds the final capture, so use the post-capture count
            if (r_state == S_DRAIN) begin
                r_pass <= (w_err_next == 8'd0);
            end
        end
    end

endmodule
`default_nettype wire
